wave_pattern_sequencer: RTL



---
 rtl/wave_pattern_sequencer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/wave_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : wave_pattern_sequencer
// Purpose  : Programmable step sequencer for the wave generator oscillator.
//            Plays a table of (waveform, frequency word, duration) entries in
//            order, with each step timed by an external tick strobe.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            wr_en/wr_addr/    - single-cycle table write port (usable in any
//            wr_wave/wr_freq/    state)
//            wr_dur
//            length, loop_en   - steps to play (sampled at start), wrap mode
//            start, stop, tick - playback control and timebase strobe
//            wave_sel, freq_word, osc_en - registered oscillator controls
//            step_idx, busy, done        - registered status
// Revision : 1.0 - initial release
// ============================================================================
module wave_pattern_sequencer #(
    parameter int DEPTH  = 8,
    parameter int FREQ_W = 8,
    parameter int DUR_W  = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [1:0]        wr_wave,
    input  logic [FREQ_W-1:0] wr_freq,
    input  logic [DUR_W-1:0]  wr_dur,
    input  logic [AW:0]       length,
    input  logic              loop_en,
    input  logic              start,
    input  logic              stop,
    input  logic              tick,
    output logic [1:0]        wave_sel,
    output logic [FREQ_W-1:0] freq_word,
    output logic              osc_en,
    output logic [AW-1:0]     step_idx,
    output logic              busy,
    output logic              done
);

    localparam logic [AW:0]      c_depth    = (AW+1)'(DEPTH);
    localparam logic [AW:0]      c_len_one  = (AW+1)'(1);
    localparam logic [DUR_W-1:0] c_dur_one  = DUR_W'(1);
    localparam logic [1:0]       c_wave_rest = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Pattern table (not reset; contents undefined until written)
    logic [1:0]        r_mem_wave [DEPTH];
    logic [FREQ_W-1:0] r_mem_freq [DEPTH];
    logic [DUR_W-1:0]  r_mem_dur  [DEPTH];

    state_t            r_state,    w_state_nxt;
    logic [AW-1:0]     r_idx,      w_idx_nxt;
    logic [AW:0]       r_len,      w_len_nxt;
    logic [DUR_W-1:0]  r_rem,      w_rem_nxt;
    logic [1:0]        r_wave_sel, w_wave_nxt;
    logic [FREQ_W-1:0] r_freq,     w_freq_nxt;
    logic              r_osc_en,   w_osc_nxt;
    logic [AW-1:0]     r_step_idx, w_step_nxt;
    logic              r_busy,     w_busy_nxt;
    logic              r_done,     w_done_nxt;

    logic [1:0]        w_ent_wave;
    logic [FREQ_W-1:0] w_ent_freq;
    logic [DUR_W-1:0]  w_ent_dur;
    logic              w_more_steps;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem_wave[wr_addr] <= wr_wave;
            r_mem_freq[wr_addr] <= wr_freq;
            r_mem_dur[wr_addr]  <= wr_dur;
        end
    end

    // Entry is only read in LOAD, so a write to the playing entry is seen at
    // its next load rather than disturbing the current outputs.
    assign w_ent_wave = r_mem_wave[r_idx];
    assign w_ent_freq = r_mem_freq[r_idx];
    assign w_ent_dur  = r_mem_dur[r_idx];

    // True when idx is not the last step of the sampled length
    assign w_more_steps = (({1'b0, r_idx} + c_len_one) < r_len);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_len      <= '0;
            r_rem      <= '0;
            r_wave_sel <= '0;
            r_freq     <= '0;
            r_osc_en   <= 1'b0;
            r_step_idx <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_len      <= w_len_nxt;
            r_rem      <= w_rem_nxt;
            r_wave_sel <= w_wave_nxt;
            r_freq     <= w_freq_nxt;
            r_osc_en   <= w_osc_nxt;
            r_step_idx <= w_step_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Outputs are registered alongside the state: each value below is what
    // the output must show while the FSM sits in w_state_nxt.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_len_nxt   = r_len;
        w_rem_nxt   = r_rem;
        w_wave_nxt  = r_wave_sel;
        w_freq_nxt  = r_freq;
        w_osc_nxt   = r_osc_en;
        w_step_nxt  = r_step_idx;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        if (stop) begin
            // Abort wins over start and tick in the same cycle
            w_state_nxt = ST_IDLE;
            w_osc_nxt   = 1'b0;
            w_busy_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && (length != '0)) begin
                        w_len_nxt   = (length > c_depth) ? c_depth : length;
                        w_idx_nxt   = '0;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    w_wave_nxt  = w_ent_wave;
                    w_freq_nxt  = w_ent_freq;
                    w_step_nxt  = r_idx;
                    w_rem_nxt   = (w_ent_dur == '0) ? c_dur_one : w_ent_dur;
                    w_osc_nxt   = (w_ent_wave != c_wave_rest);
                    w_state_nxt = ST_PLAY;
                end
                ST_PLAY: begin
                    if (tick) begin
                        if (r_rem > c_dur_one) begin
                            w_rem_nxt = r_rem - c_dur_one;
                        end else if (w_more_steps) begin
                            w_idx_nxt   = r_idx + AW'(1);
                            w_state_nxt = ST_LOAD;
                        end else if (loop_en) begin
                            w_idx_nxt   = '0;
                            w_state_nxt = ST_LOAD;
                        end else begin
                            w_osc_nxt   = 1'b0;
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign wave_sel  = r_wave_sel;
    assign freq_word = r_freq;
    assign osc_en    = r_osc_en;
    assign step_idx  = r_step_idx;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire
